// File: rtl/link_capture_buffer.sv
`default_nettype none
// link_capture_buffer: arm/trigger capture of the aligned e-link word stream into a
// DEPTH-word RAM, drained in write order over a valid/ready read port.
module link_capture_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk160,
  input  logic          rst,
  input  logic [31:0]   data_in,
  input  logic          aligned,
  input  logic          arm,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [31:0]   trig_word,
  input  logic [AW:0]   cap_len,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   words_stored,
  output logic          align_lost
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_ARMED   = 2'd1;
  localparam logic [1:0]  S_CAPTURE = 2'd2;
  localparam logic [1:0]  S_READOUT = 2'd3;
  localparam logic [AW:0] C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE     = (AW+1)'(1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] trig_q, trig_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] wcnt_q, wcnt_d;
  logic        lost_q, lost_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] xcnt_q, xcnt_d;
  logic        ram_vld_q, ram_vld_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] ram_q;

  logic        trig_hit;
  logic        xfer;
  logic        out_load;
  logic        issue;
  logic        wr_en;
  logic [31:0] mem [DEPTH];

  always_comb begin
    trig_hit = 1'b1;
    case (mode_q)
      2'd1:    trig_hit = aligned;
      2'd2:    trig_hit = aligned && (data_in == trig_q);
      default: trig_hit = 1'b1;
    endcase
  end

  // Two-stage read pipe (RAM register, output register); a new read is issued
  // only when the RAM register is empty or drains this cycle.
  assign xfer     = rd_valid_q && rd_ready;
  assign out_load = ram_vld_q && (!rd_valid_q || xfer);
  assign issue    = (state_q == S_READOUT) && (rptr_q != len_q) && (!ram_vld_q || out_load);
  assign wr_en    = !abort && (((state_q == S_ARMED) && trig_hit) || (state_q == S_CAPTURE));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    trig_d     = trig_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    lost_d     = lost_q;
    rptr_d     = rptr_q;
    xcnt_d     = xcnt_q;
    ram_vld_d  = ram_vld_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (issue) begin
      rptr_d    = rptr_q + C_ONE;
      ram_vld_d = 1'b1;
    end else if (out_load) begin
      ram_vld_d = 1'b0;
    end

    if (out_load) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ram_q;
    end else if (xfer) begin
      rd_valid_d = 1'b0;
    end

    if (xfer) xcnt_d = xcnt_q + C_ONE;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          mode_d  = mode;
          trig_d  = trig_word;
          len_d   = ((cap_len == '0) || (cap_len > C_DEPTH)) ? C_DEPTH : cap_len;
          wcnt_d  = '0;
          lost_d  = 1'b0;
          rptr_d  = '0;
          xcnt_d  = '0;
        end
      end
      S_ARMED: begin
        if (trig_hit) begin
          wcnt_d  = C_ONE;
          state_d = (len_q == C_ONE) ? S_READOUT : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        wcnt_d = wcnt_q + C_ONE;
        if (((mode_q == 2'd1) || (mode_q == 2'd2)) && !aligned) lost_d = 1'b1;
        if ((wcnt_q + C_ONE) == len_q) state_d = S_READOUT;
      end
      default: begin
        if (xfer && ((xcnt_q + C_ONE) == len_q)) begin
          state_d    = S_IDLE;
          rd_valid_d = 1'b0;
          ram_vld_d  = 1'b0;
        end
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      ram_vld_d  = 1'b0;
      wcnt_d     = wcnt_q;
      lost_d     = lost_q;
    end
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      trig_q     <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      lost_q     <= 1'b0;
      rptr_q     <= '0;
      xcnt_q     <= '0;
      ram_vld_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      trig_q     <= trig_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      lost_q     <= lost_d;
      rptr_q     <= rptr_d;
      xcnt_q     <= xcnt_d;
      ram_vld_q  <= ram_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Capture RAM: contents deliberately not reset.
  always_ff @(posedge clk160) begin
    if (wr_en) mem[wcnt_q[AW-1:0]] <= data_in;
    if (issue) ram_q <= mem[rptr_q[AW-1:0]];
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done         = (state_q == S_READOUT);
  assign words_stored = wcnt_q;
  assign align_lost   = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_link_capture_buffer.sv
`default_nettype none
// Bench for link_capture_buffer: directed and randomised captures checked against
// a queue model built from the trigger/length rules.
module tb_link_capture_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk160 = 1'b0;
  logic          rst, aligned, arm, abort, rd_ready;
  logic [31:0]   data_in, trig_word;
  logic [1:0]    mode;
  logic [AW:0]   cap_len;
  logic [31:0]   rd_data;
  logic          rd_valid, busy, done, align_lost;
  logic [AW:0]   words_stored;

  int errors = 0;
  int checks = 0;

  logic [31:0] sd [64];
  logic        sa [64];
  logic [31:0] got [$];
  logic [31:0] exp_q [$];
  logic        exp_lost;
  int          exp_ti, exp_len;
  int          first_done, first_valid, stall_bad, both_bad, extra_valid;
  bit          timeout;

  link_capture_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk160(clk160), .rst(rst), .data_in(data_in), .aligned(aligned),
    .arm(arm), .abort(abort), .mode(mode), .trig_word(trig_word),
    .cap_len(cap_len), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .busy(busy), .done(done),
    .words_stored(words_stored), .align_lost(align_lost)
  );

  always #3 clk160 = ~clk160;

  task automatic tick;
    @(posedge clk160);
    #1;
  endtask

  // Expected capture: first stream index meeting the trigger, then L consecutive words.
  function automatic void model_capture(input int m, input logic [31:0] tw, input int cl);
    exp_len = (cl == 0 || cl > DEPTH) ? DEPTH : cl;
    exp_q.delete();
    exp_lost = 1'b0;
    exp_ti   = -1;
    for (int i = 0; i < 64; i++) begin
      if (m == 1 && !sa[i]) continue;
      if (m == 2 && !(sa[i] && sd[i] == tw)) continue;
      exp_ti = i;
      break;
    end
    if (exp_ti < 0) return;
    for (int i = exp_ti; i < exp_ti + exp_len; i++) begin
      exp_q.push_back(sd[i]);
      if (i > exp_ti && (m == 1 || m == 2) && !sa[i]) exp_lost = 1'b1;
    end
  endfunction

  task automatic drive_capture(input int m, input logic [31:0] tw, input int cl,
                               input int rdy_mode, input int rearm_k);
    logic        pv, pr, seen_done;
    logic [31:0] pd;
    int          k;
    got.delete();
    first_done = -1; first_valid = -1; stall_bad = 0; both_bad = 0; timeout = 0;
    arm = 1'b1; mode = m[1:0]; trig_word = tw; cap_len = cl[AW:0];
    data_in = $urandom; aligned = 1'b1; rd_ready = 1'b0;
    tick;
    arm = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0; seen_done = 1'b0; k = 0;
    while (1) begin
      data_in = (k < 64) ? sd[k] : $urandom;
      aligned = (k < 64) ? sa[k] : 1'b1;
      arm = (k == rearm_k);
      if (arm) cap_len = ~cap_len;
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 5 == 0) || (k % 5 == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (pv && !pr && (rd_valid !== 1'b1 || rd_data !== pd)) stall_bad++;
      if (busy && done) both_bad++;
      if (done && first_done < 0) first_done = k;
      if (rd_valid && first_valid < 0) first_valid = k;
      if (rd_valid && rd_ready) got.push_back(rd_data);
      if (done) seen_done = 1'b1;
      if (seen_done && !done) break;
      if (k > 400) begin timeout = 1; break; end
      pv = rd_valid; pr = rd_ready; pd = rd_data;
      tick;
      k++;
    end
    arm = 1'b0;
    extra_valid = 0;
    rd_ready = 1'b1;
    repeat (3) begin
      if (rd_valid || busy || done) extra_valid++;
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; arm = 0; abort = 0; rd_ready = 0; aligned = 0;
    data_in = '0; mode = '0; trig_word = '0; cap_len = '0;
    repeat (3) tick;
    rst = 1'b0;
    checks++;
    if ({rd_data, rd_valid, busy, done, words_stored, align_lost} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b busy=%b done=%b ws=%0d lost=%b, required all 0",
               rd_data, rd_valid, busy, done, words_stored, align_lost);
    end
  endtask

  task automatic test_mode0;
    for (int i = 0; i < 64; i++) begin sd[i] = 32'h100 + i; sa[i] = 1'b1; end
    model_capture(0, 32'h0, 4);
    drive_capture(0, 32'h0, 4, 0, -1);
    checks++;
    if (timeout || got.size() != 4) begin
      errors++; $display("FAIL m0_count: got %0d words timeout=%0d, required 4", got.size(), timeout);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL m0_word%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (first_done !== 4) begin errors++; $display("FAIL m0_done_time: got k=%0d required 4", first_done); end
    checks++;
    if (words_stored !== 5'd4 || extra_valid !== 0) begin
      errors++; $display("FAIL m0_end: got ws=%0d extra=%0d required ws=4 extra=0", words_stored, extra_valid);
    end
  endtask

  task automatic test_mode2_trigger;
    for (int i = 0; i < 64; i++) begin sd[i] = 32'h1000 + i; sa[i] = 1'b1; end
    sd[0] = 32'h1; sd[1] = 32'h2; sd[2] = 32'hACCCCCCC; sd[3] = 32'h3; sd[4] = 32'h4; sd[5] = 32'h5;
    model_capture(2, 32'hACCCCCCC, 3);
    drive_capture(2, 32'hACCCCCCC, 3, 0, -1);
    checks++;
    if (timeout || got.size() != 3) begin
      errors++; $display("FAIL m2_count: got %0d words timeout=%0d, required 3", got.size(), timeout);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL m2_word%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (align_lost !== 1'b0) begin errors++; $display("FAIL m2_lost: got %b required 0", align_lost); end
  endtask

  task automatic test_align_lost;
    for (int i = 0; i < 64; i++) begin sd[i] = 32'h200 + i; sa[i] = 1'b1; end
    sa[3] = 1'b0; sd[3] = '0; sa[4] = 1'b0; sd[4] = '0;
    model_capture(1, 32'h0, 8);
    drive_capture(1, 32'h0, 8, 0, -1);
    checks++;
    if (timeout || got.size() != 8) begin
      errors++; $display("FAIL lost_count: got %0d words timeout=%0d, required 8", got.size(), timeout);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL lost_word%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (align_lost !== exp_lost || exp_lost !== 1'b1) begin
      errors++; $display("FAIL lost_flag: got %b required %b", align_lost, exp_lost);
    end
    arm = 1'b1; mode = 2'd0; cap_len = 5'd4;
    tick;
    arm = 1'b0; abort = 1'b1;
    checks++;
    if (align_lost !== 1'b0 || words_stored !== '0) begin
      errors++; $display("FAIL lost_clear: got lost=%b ws=%0d required 0/0", align_lost, words_stored);
    end
    tick;
    abort = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 64; i++) begin sd[i] = 32'h300 + i; sa[i] = 1'b1; end
    model_capture(0, 32'h0, 5);
    drive_capture(0, 32'h0, 5, 1, -1);
    checks++;
    if (timeout || got.size() != 5 || stall_bad != 0 || extra_valid != 0) begin
      errors++;
      $display("FAIL bp_flow: got words=%0d stall_err=%0d extra=%0d timeout=%0d required 5/0/0/0",
               got.size(), stall_bad, extra_valid, timeout);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundaries;
    int cls [3] = '{0, 1, 6};
    int rks [3] = '{-1, -1, 2};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) begin sd[i] = $urandom; sa[i] = 1'b1; end
      model_capture(0, 32'h0, cls[t]);
      drive_capture(0, 32'h0, cls[t], 0, rks[t]);
      checks++;
      if (timeout || got.size() != exp_len || got != exp_q) begin
        errors++; $display("FAIL bound_len%0d: got %0d words required %0d (content match=%0d)",
                           cls[t], got.size(), exp_len, got == exp_q);
      end
      checks++;
      if (first_done !== exp_len || words_stored !== exp_len[AW:0]) begin
        errors++; $display("FAIL bound_done%0d: got done_k=%0d ws=%0d required %0d/%0d",
                           cls[t], first_done, words_stored, exp_len, exp_len);
      end
    end
  endtask

  task automatic test_abort;
    int vcount;
    for (int i = 0; i < 64; i++) sd[i] = 32'h400 + i;
    arm = 1'b1; mode = 2'd0; cap_len = 5'd8; aligned = 1'b1; rd_ready = 1'b1;
    tick;
    arm = 1'b0;
    for (int k = 0; k < 3; k++) begin data_in = sd[k]; tick; end
    data_in = sd[3]; abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || words_stored !== 5'd3 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL abort_cap: got busy=%b done=%b ws=%0d v=%b required 0/0/3/0",
                         busy, done, words_stored, rd_valid);
    end
    vcount = 0;
    repeat (4) begin if (rd_valid || busy || done) vcount++; tick; end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL abort_idle: got %0d active cycles required 0", vcount); end
    arm = 1'b1; abort = 1'b1; cap_len = 5'd4;
    tick;
    arm = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || words_stored !== 5'd3) begin
      errors++; $display("FAIL abort_arm: got busy=%b ws=%0d required 0/3", busy, words_stored);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_arm_hold: got busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_reset_readout;
    int n, vcount;
    for (int i = 0; i < 64; i++) begin sd[i] = 32'h500 + i; sa[i] = 1'b1; end
    sa[1] = 1'b0; sd[1] = '0;
    arm = 1'b1; mode = 2'd1; cap_len = 5'd4; rd_ready = 1'b0;
    tick;
    arm = 1'b0;
    n = 0;
    while (!rd_valid && n < 30) begin data_in = sd[n]; aligned = sa[n]; tick; n++; end
    checks++;
    if (!rd_valid) begin errors++; $display("FAIL rst_rd_reach: got rd_valid=%b required 1", rd_valid); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({rd_data, rd_valid, busy, done, words_stored, align_lost} !== '0) begin
      errors++;
      $display("FAIL rst_readout: got data=%h v=%b busy=%b done=%b ws=%0d lost=%b, required all 0",
               rd_data, rd_valid, busy, done, words_stored, align_lost);
    end
    rd_ready = 1'b1; vcount = 0;
    repeat (4) begin if (rd_valid || done) vcount++; tick; end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL rst_no_read: got %0d active cycles required 0", vcount); end
  endtask

  task automatic test_random;
    int m, cl, pos;
    logic [31:0] tw;
    for (int r = 0; r < 8; r++) begin
      m  = $urandom_range(0, 3);
      cl = $urandom_range(0, 31);
      tw = $urandom;
      for (int i = 0; i < 64; i++) begin
        sa[i] = ($urandom_range(0, 7) != 0);
        sd[i] = sa[i] ? $urandom : 32'h0;
        if (sd[i] == tw) sd[i] = ~tw;
      end
      pos = $urandom_range(0, 10);
      sd[pos] = tw; sa[pos] = 1'b1;
      model_capture(m, tw, cl);
      drive_capture(m, tw, cl, 2, -1);
      checks++;
      if (timeout || got != exp_q) begin
        errors++; $display("FAIL rand%0d_data: mode=%0d len=%0d got %0d words required %0d (timeout=%0d)",
                           r, m, cl, got.size(), exp_q.size(), timeout);
      end
      checks++;
      if (words_stored !== exp_len[AW:0] || align_lost !== exp_lost || first_done !== exp_ti + exp_len) begin
        errors++; $display("FAIL rand%0d_status: got ws=%0d lost=%b done_k=%0d required %0d/%b/%0d",
                           r, words_stored, align_lost, first_done, exp_len, exp_lost, exp_ti + exp_len);
      end
      checks++;
      if (stall_bad != 0 || both_bad != 0 || extra_valid != 0 || first_valid > first_done + 2) begin
        errors++; $display("FAIL rand%0d_proto: got stall=%0d both=%0d extra=%0d valid_k=%0d required 0/0/0/<=%0d",
                           r, stall_bad, both_bad, extra_valid, first_valid, first_done + 2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode2_trigger;
    test_align_lost;
    test_backpressure;
    test_boundaries;
    test_abort;
    test_reset_readout;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_capture_buffer.md
Name: link_capture_buffer

Overview:
- Downstream consumer of the per-link bit-alignment stage. Takes the aligned 32-bit word stream and its match/aligned flag at 160 MHz.
- On software arm plus a selectable trigger condition, stores a programmable number of consecutive words into an internal RAM.
- Presents the stored words on a valid/ready read port for the link-capture register interface / DMA.
- One instance per e-link.

Parameters:
- DEPTH, 512, capture RAM depth in 32-bit words; power of two, minimum 4.
- AW, 9, address width, equal to log2(DEPTH).

Ports:
- clk160  in  1  capture clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  32  aligned word from the alignment stage; zero when not aligned.
- aligned  in  1  alignment flag from the alignment stage (its match output).
- arm  in  1  single-cycle arm request.
- abort  in  1  single-cycle abort; returns the block to IDLE.
- mode  in  2  trigger mode, sampled on arm: 0 immediate, 1 on aligned, 2 on aligned and data_in==trig_word, 3 reserved (behaves as 0).
- trig_word  in  32  trigger pattern, sampled on arm.
- cap_len  in  AW+1  words to capture, sampled on arm; 0 or greater than DEPTH means DEPTH.
- rd_data  out  32  readout word.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts; a transfer occurs when rd_valid and rd_ready are both high.
- busy  out  1  state is ARMED or CAPTURE.
- done  out  1  state is READOUT.
- words_stored  out  AW+1  words written in the current/last capture.
- align_lost  out  1  sticky: aligned was low during a CAPTURE cycle in mode 1/2.

Behaviour:
- Reset: state IDLE; all outputs 0; pointers 0. RAM contents are not reset.
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE:
  - arm=1 → ARMED next cycle.
  - On arm, latch mode, trig_word and effective length L; clear words_stored and align_lost.
- ARMED: trigger is evaluated each cycle on the current inputs.
  - mode 0/3: trigger true on the first ARMED cycle.
  - mode 1: trigger when aligned=1.
  - mode 2: trigger when aligned=1 and data_in==trig_word.
  - On the trigger cycle, data_in is written to address 0, words_stored becomes 1, and the state moves to CAPTURE.
  - If L==1, go straight to READOUT instead.
- CAPTURE:
  - Each cycle, write data_in at address words_stored and increment words_stored.
  - Move to READOUT in the cycle the L-th word is written.
  - Exactly L words are stored, with no gaps or duplicates.
  - In mode 1/2, aligned=0 in any CAPTURE cycle sets align_lost; capture continues.
- READOUT:
  - done=1.
  - Read pointer starts at 0; RAM read has 1-cycle latency behind an output register.
  - rd_valid first rises no later than 2 cycles after entering READOUT.
  - Words are presented in write order, and each word is presented exactly once.
  - rd_data and rd_valid are held stable while rd_valid=1 and rd_ready=0.
  - Back-to-back transfers at 1 word/cycle are supported when rd_ready is held high.
  - After the L-th transfer: rd_valid=0, state returns to IDLE, done=0.
  - words_stored and align_lost hold until the next arm.
- arm outside IDLE is ignored.
- abort in any state: next cycle the state is IDLE and rd_valid=0; words_stored and align_lost hold.
- abort has priority over arm, trigger and transfer in the same cycle.
- arm and abort together in IDLE: abort wins; the block stays IDLE.
- rst mid-capture or mid-readout behaves as full reset; a partial capture is not readable.
- busy and done are mutually exclusive and never both 1.

Test Plan:
- Mode 0, cap_len=4, data_in counting 0x100,0x101,...; arm in cycle t → addresses 0..3 hold the words present at t+1..t+4; done rises at t+5; with rd_ready=1 the read sequence is exactly 4 words of +1 increments; back to IDLE; words_stored=4.
- Mode 2, trig_word=0xACCCCCCC, cap_len=3; aligned=1; stream 0x1,0x2,0xACCCCCCC,0x3,0x4,0x5 → reads 0xACCCCCCC,0x3,0x4; align_lost=0.
- Mode 1, cap_len=8; aligned high at capture start, then dropped for 2 cycles mid-capture → 8 words stored including two 0x00000000; align_lost=1; it clears on the next arm.
- Readout backpressure: cap_len=5; rd_ready toggled 1,0,0,1,0,1... → each of the 5 words is accepted exactly once, in order; rd_data stable during stalls; no extra valid cycle after the 5th.
- Boundaries: cap_len=0 with DEPTH=16 → 16 words captured. cap_len=1 → ARMED goes directly to READOUT and exactly 1 word is read. arm during CAPTURE → ignored, length unchanged.
- Abort/reset: abort during CAPTURE after 3 of 8 words → IDLE next cycle, words_stored=3, no rd_valid. abort+arm in the same IDLE cycle → stays IDLE. rst during READOUT → all outputs 0 next cycle.
